// File: rtl/gate_truth_checker.sv
// Stimulus/response self-test for a 2-input gate bank (and, nand, nor, or, xnor, xor).
// Latency: done pulses 4*(SETTLE_CYCLES+1) cycles after the start-accept edge.
// Backpressure: none; start is only sampled in IDLE, ignored while a run is in progress.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [5:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [5:0] err_gate_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Settle counter reload; a value of 0 means a single SETTLE cycle.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [5:0] exp_y;
    logic [5:0] mism;
    logic       vec_fail;
    logic [2:0] err_next;

    // Golden truth table for the vector currently driven onto the bank.
    assign exp_y    = {a_out & b_out, ~(a_out & b_out), ~(a_out | b_out),
                       a_out | b_out, ~(a_out ^ b_out), a_out ^ b_out};
    assign mism     = y_in ^ exp_y;
    assign vec_fail = |mism;
    // At most four vectors fail, so this never wraps.
    assign err_next = err_count + {2'b00, vec_fail};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_nxt = CHECK;
            CHECK:   state_nxt = (idx == 2'd3) ? FINISH : SETTLE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector sequencing, response compare and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= 2'd0;
            cnt           <= 4'd0;
            a_out         <= 1'b0;
            b_out         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 3'd0;
            fail_mask     <= 4'd0;
            err_gate_mask <= 6'd0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        idx            <= 2'd0;
                        {a_out, b_out} <= 2'b00;
                        cnt            <= CNT_LOAD;
                        pass           <= 1'b0;
                        err_count      <= 3'd0;
                        fail_mask      <= 4'd0;
                        err_gate_mask  <= 6'd0;
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                CHECK: begin
                    if (vec_fail) begin
                        fail_mask[idx] <= 1'b1;
                        err_count      <= err_next;
                        err_gate_mask  <= err_gate_mask | mism;
                    end
                    if (idx == 2'd3) begin
                        // pass uses the count including this last vector.
                        done <= 1'b1;
                        pass <= (err_next == 3'd0);
                    end else begin
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                        cnt            <= CNT_LOAD;
                    end
                end
                FINISH: begin
                    {a_out, b_out} <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Synthesizable stimulus and response checker for a 2-input gate bank with six outputs: and, nand, nor, or, xnor, xor.
- On start, it drives all four input vectors onto the bank's A/B inputs, waits a settle window, and compares the six returned outputs against the golden truth table.
- It reports pass/fail, an error count, a per-vector fail mask and a per-gate fail mask.
- It sits on the far side of the gate-bank interface. It replaces a simulation-only stimulus/display bench with on-chip self-test.

Parameters:
- SETTLE_CYCLES, 1, number of cycles A/B are held before the outputs are sampled. Legal range 1..15, held in a 4-bit counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  run request; sampled only in IDLE.
- a_out  output  1  drives the gate bank's A input.
- b_out  output  1  drives the gate bank's B input.
- y_in  input  6  gate bank outputs, {and, nand, nor, or, xnor, xor}, where [5]=and and [0]=xor.
- busy  output  1  high while a run is in progress (SETTLE, CHECK, FINISH).
- done  output  1  one-cycle pulse when results are valid.
- pass  output  1  1 when the last run had zero mismatches.
- err_count  output  3  number of failing vectors in the last run, 0..4.
- fail_mask  output  4  bit i set when vector i ({a,b}=i) had any mismatch.
- err_gate_mask  output  6  OR over all vectors of the mismatching y bits; same bit order as y_in.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, err_gate_mask=0.
  - The vector index and the settle counter are cleared.
  - Reset mid-run aborts the run immediately, with no done pulse.
- States: IDLE, SETTLE, CHECK, FINISH.
- IDLE -> SETTLE:
  - Occurs on an edge with start=1.
  - At that edge: idx=0, {a_out,b_out}=2'b00, cnt=SETTLE_CYCLES-1.
  - All result outputs are cleared: pass=0, err_count=0, fail_mask=0, err_gate_mask=0.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles.
  - If cnt==0, go to CHECK; otherwise cnt decrements.
- CHECK (one cycle):
  - y_in is compared with the expected value exp = {a&b, ~(a&b), ~(a|b), a|b, ~(a^b), a^b}, computed from the currently driven a_out/b_out.
  - On mismatch: fail_mask[idx]=1, err_count+1, err_gate_mask |= y_in^exp.
  - If idx==3, go to FINISH.
  - Otherwise: idx+1, {a_out,b_out}=idx+1, cnt=SETTLE_CYCLES-1, go to SETTLE.
- Vector timing:
  - Each vector is held on a_out/b_out for SETTLE_CYCLES+1 cycles.
  - y_in is sampled only at the final edge of that window.
  - Vector order is 00, 01, 10, 11.
- FINISH (one cycle):
  - done=1, pass=(err_count==0), busy=1; next state IDLE.
  - {a_out,b_out} return to 00 on exit.
- Latency: done is high in the cycle that starts 4*(SETTLE_CYCLES+1) edges after the start-accept edge. With SETTLE_CYCLES=1 that is cycle 8.
- Result hold: pass, err_count, fail_mask and err_gate_mask hold their values after done until the next accepted start or reset.
- start handling:
  - start is ignored in SETTLE, CHECK and FINISH.
  - start high in IDLE is a new request even if it was held from an earlier run. A level-held start therefore reruns back-to-back, with one IDLE cycle between runs.
- done, busy, a_out and b_out are registered outputs. No combinational path exists from y_in to any output.
- err_count saturates by construction at 4 (at most 4 vectors).

Test Plan:
1. Ideal gate model with SETTLE_CYCLES=1, one-cycle start pulse:
   - a/b go 00,01,10,11, each held 2 cycles.
   - done pulses in cycle 8 after accept.
   - pass=1, err_count=0, fail_mask=0000, err_gate_mask=000000.
2. and output stuck at 0 -> pass=0, err_count=1, fail_mask=1000, err_gate_mask=100000.
3. xor output inverted -> pass=0, err_count=4, fail_mask=1111, err_gate_mask=000001.
4. start pulsed again during SETTLE of vector 1:
   - The pulse is ignored; the single done arrives at cycle 8.
   - With start held high, a second run is accepted one cycle after FINISH, and the results are cleared at that edge.
5. rst_n low for one edge during vector 2 SETTLE:
   - Next cycle: busy=0, a/b=00, all results 0, no done.
   - A following start completes normally with pass=1.
6. SETTLE_CYCLES=3 with the gate model behind a 2-cycle register delay:
   - Each vector is held 4 cycles, done arrives at cycle 16, pass=1.
   - The same model with SETTLE_CYCLES=1 gives pass=0.
